// File: rtl/uart_tx_fifo_param_if.sv
// uart_tx_fifo_param_if: write-side bus of the UART TX FIFO (strobe, data, level/status flags).
interface uart_tx_fifo_param_if #(
    parameter int DBIT       = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_uart;
    logic [DBIT-1:0]               w_data;
    logic                          tx_full;
    logic                          tx_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          incorrect_send;
    modport master (output wr_uart, w_data, input tx_full, tx_empty, fifo_level, incorrect_send);
    modport slave  (input wr_uart, w_data, output tx_full, tx_empty, fifo_level, incorrect_send);
endinterface

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: TX FIFO feeding a 16x-oversampled UART serialiser with optional parity
// and two stop bits. Define UART_TX_BREAK_EN to add the send_break input and BREAK state.
module uart_tx_fifo_param #(
    parameter int DBIT       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DVSR_W     = 10
) (
    input  logic                CLK,
    input  logic                Reset,
    uart_tx_fifo_param_if.slave wbus,
    input  logic [DVSR_W-1:0]   divsr,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                send_break,
`endif
    output logic                tx,
    output logic                tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] NLAST = 4'(DBIT - 1);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, BRK_STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t            state;
    logic [DBIT-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic              full, empty, push, pop, tick, hold, stop_end, brk_req;
    logic [DVSR_W-1:0] cnt, divsr_l;
    logic [4:0]        s_cnt;
    logic [3:0]        n;
    logic [DBIT-1:0]   sh;
    logic              par_bit, parity_en_l, stop2_l;

`ifdef UART_TX_BREAK_EN
    assign brk_req = send_break;
    assign hold    = (state == IDLE) || (state == BRK);
`else
    assign brk_req = 1'b0;
    assign hold    = state == IDLE;
`endif

    assign full     = level == (AW+1)'(FIFO_DEPTH);
    assign empty    = level == '0;
    assign push     = wbus.wr_uart && !full;
    assign tick     = cnt == divsr_l;
    assign stop_end = (state == STOP) && tick && (s_cnt == (stop2_l ? 5'd31 : 5'd15));
    assign pop      = !empty && (((state == IDLE) && !brk_req) || stop_end);
    assign tx_done  = stop_end;

    assign wbus.tx_full    = full;
    assign wbus.tx_empty   = empty;
    assign wbus.fifo_level = level;

    // FIFO storage: written on accepted pushes only.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wbus.w_data;
    end

    // FIFO pointers, level and the rejected-write pulse (judged on the pre-edge full flag).
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            level               <= '0;
            wbus.incorrect_send <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level               <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            wbus.incorrect_send <= wbus.wr_uart && full;
        end
    end

    // Frame sequencer: steps through the frame on 16 ticks per bit and drives tx from a register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            cnt         <= '0;
            s_cnt       <= '0;
            n           <= '0;
            sh          <= '0;
            par_bit     <= 1'b0;
            divsr_l     <= '0;
            parity_en_l <= 1'b0;
            stop2_l     <= 1'b0;
        end else begin
            cnt <= (hold || tick) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (send_break) begin
                        state   <= BRK;
                        tx      <= 1'b0;
                        divsr_l <= divsr;
                    end else
`endif
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: if (tick) begin
                    if (s_cnt == 5'd15) begin
                        s_cnt <= '0;
                        state <= DATA;
                        tx    <= sh[0];
                    end else s_cnt <= s_cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (s_cnt == 5'd15) begin
                        s_cnt <= '0;
                        sh    <= sh >> 1;
                        if (n == NLAST) begin
                            state <= parity_en_l ? PARITY : STOP;
                            tx    <= parity_en_l ? par_bit : 1'b1;
                        end else begin
                            n  <= n + 1'b1;
                            tx <= sh[1];
                        end
                    end else s_cnt <= s_cnt + 1'b1;
                end
                PARITY: if (tick) begin
                    if (s_cnt == 5'd15) begin
                        s_cnt <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else s_cnt <= s_cnt + 1'b1;
                end
                STOP: if (stop_end) begin
                    s_cnt <= '0;
                    state <= pop ? START : IDLE;
                    tx    <= !pop;
                end else if (tick) s_cnt <= s_cnt + 1'b1;
`ifdef UART_TX_BREAK_EN
                BRK: if (!send_break) begin
                    s_cnt <= '0;
                    state <= BRK_STOP;
                    tx    <= 1'b1;
                end
                BRK_STOP: if (tick) begin
                    if (s_cnt == 5'd15) begin
                        s_cnt <= '0;
                        state <= IDLE;
                    end else s_cnt <= s_cnt + 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
            if (pop) begin
                sh          <= mem[rd_ptr];
                par_bit     <= ^mem[rd_ptr] ^ parity_odd;
                divsr_l     <= divsr;
                parity_en_l <= parity_en;
                stop2_l     <= stop2;
                s_cnt       <= '0;
                n           <= '0;
            end
        end
    end
endmodule
